// File: rtl/pipelined_adder_carry.sv
// Pipelined adder/subtractor that resolves one SEG-bit carry segment per stage.
// Operands are skewed in and results de-skewed so every SUM bit leaves together.
module pipelined_adder_carry #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    logic [WIDTH-1:0] b_eff;
    assign b_eff = sub ? ~b : b;

    // Handshake: in_valid qualifies a/b/ci/sub on an enabled edge; out_valid
    // qualifies sum/co/ovf; en low freezes every register, no other backpressure.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - k * SEG;
        localparam int LO = k * SEG;

        logic [HI-1:0]     op_a;
        logic [HI-1:0]     op_b;
        logic              c_in;
        logic              v_in;
        logic [SEG-1:0]    seg_res;
        logic              c_out;
        logic [LO+SEG-1:0] res_out;

        if (k == 0) begin : g_head
            assign op_a    = a;
            assign op_b    = b_eff;
            assign c_in    = ci;
            assign v_in    = in_valid;
            assign res_out = seg_res;
        end else begin : g_skew
            // Upper operand segments still waiting for their stage, lower results already done.
            logic [LO-1:0] res_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    op_a  <= '0;
                    op_b  <= '0;
                    c_in  <= 1'b0;
                    v_in  <= 1'b0;
                    res_q <= '0;
                end else if (en) begin
                    op_a  <= g_stage[k-1].op_a[HI+SEG-1:SEG];
                    op_b  <= g_stage[k-1].op_b[HI+SEG-1:SEG];
                    c_in  <= g_stage[k-1].c_out;
                    v_in  <= g_stage[k-1].v_in;
                    res_q <= g_stage[k-1].res_out;
                end
            end

            assign res_out = {seg_res, res_q};
        end

        if (k < STAGES - 1) begin : g_mid
            logic [SEG:0] seg_sum;

            assign seg_sum = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]}
                           + {{SEG{1'b0}}, c_in};
            assign seg_res = seg_sum[SEG-1:0];
            assign c_out   = seg_sum[SEG];
        end else begin : g_tail
            // Top bit is added on its own so the carry into the MSB is visible for ovf.
            logic [SEG-1:0] low_sum;
            logic [1:0]     top_sum;

            assign low_sum = {1'b0, op_a[SEG-2:0]} + {1'b0, op_b[SEG-2:0]}
                           + {{(SEG-1){1'b0}}, c_in};
            assign top_sum = {1'b0, op_a[SEG-1]} + {1'b0, op_b[SEG-1]}
                           + {1'b0, low_sum[SEG-1]};
            assign seg_res = {top_sum[0], low_sum[SEG-2:0]};
            assign c_out   = top_sum[1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    co        <= 1'b0;
                    ovf       <= 1'b0;
                end else if (en) begin
                    out_valid <= v_in;
                    if (v_in) begin
                        sum <= res_out;
                        co  <= c_out;
                        ovf <= c_out ^ low_sum[SEG-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder_carry.sv
// Scoreboard bench for pipelined_adder_carry: 32/8 four-stage instance plus a 16/16
// single-stage instance, checked against an arithmetic reference model.
module tb_pipelined_adder_carry;
    localparam int STAGES = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic [31:0] sum;
    logic        co;
    logic        ovf;

    logic        en2;
    logic        in_valid2;
    logic [15:0] a2;
    logic [15:0] b2;
    logic        ci2;
    logic        sub2;
    logic        out_valid2;
    logic [15:0] sum2;
    logic        co2;
    logic        ovf2;

    logic [33:0] exp_q[$];
    int          lat_q[$];
    logic [17:0] exp2_q[$];
    int          lat2_q[$];

    int total = 0;
    int bad = 0;
    int accepted = 0;
    int seen = 0;
    int accepted2 = 0;
    int seen2 = 0;
    int en_edges = 0;
    int cyc = 0;
    logic last_en = 1'b0;

    pipelined_adder_carry #(.WIDTH(32), .SEG(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .sum(sum), .co(co), .ovf(ovf)
    );

    pipelined_adder_carry #(.WIDTH(16), .SEG(16)) dut1s (
        .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(in_valid2),
        .a(a2), .b(b2), .ci(ci2), .sub(sub2),
        .out_valid(out_valid2), .sum(sum2), .co(co2), .ovf(ovf2)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        last_en <= en && rst_n;
        if (rst_n && en) en_edges <= en_edges + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // reference model: plain wide addition, overflow from operand/result signs
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic s);
        logic [31:0] yy;
        logic [32:0] t;
        logic        o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {32'd0, c};
        o  = (x[31] == yy[31]) && (t[31] != x[31]);
        return {o, t[32], t[31:0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        logic [15:0] yy;
        logic [16:0] t;
        logic        o;
        yy = s ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {16'd0, c};
        o  = (x[15] == yy[15]) && (t[15] != x[15]);
        return {o, t[16], t[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // driver tasks
    task automatic drive(input logic e, input logic v, input logic [31:0] x,
                         input logic [31:0] y, input logic c, input logic s);
        en = e; in_valid = v; a = x; b = y; ci = c; sub = s;
        if (e && v) begin
            exp_q.push_back(model(x, y, c, s));
            lat_q.push_back(en_edges + STAGES);
            accepted++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic v, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic s);
        in_valid2 = v; a2 = x; b2 = y; ci2 = c; sub2 = s;
        if (v) begin
            exp2_q.push_back(model16(x, y, c, s));
            lat2_q.push_back(cyc + 1);
            accepted2++;
        end
        @(posedge clk);
        #1;
    endtask

    // monitors / scoreboard
    always @(negedge clk) begin
        if (rst_n && last_en && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result got=%h want=none", {ovf, co, sum});
            end else begin
                check("result", 64'({ovf, co, sum}), 64'(exp_q.pop_front()));
                check("latency", 64'(en_edges), 64'(lat_q.pop_front()));
                seen++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2) begin
            if (exp2_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result16 got=%h want=none", {ovf2, co2, sum2});
            end else begin
                check("result16", 64'({ovf2, co2, sum2}), 64'(exp2_q.pop_front()));
                check("latency16", 64'(cyc), 64'(lat2_q.pop_front()));
                seen2++;
            end
        end
    end

    initial begin
        int dropped;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        en2 = 1'b1; in_valid2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; sub2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_sum", 64'(sum), 64'(0));
        check("reset_co", 64'(co), 64'(0));
        check("reset_ovf", 64'(ovf), 64'(0));
        check("reset_out_valid16", 64'(out_valid2), 64'(0));
        rst_n = 1'b1;

        // directed: ripple, overflow, subtract both ways, then a bubble
        drive(1, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drive(1, 1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drive(1, 1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
        drive(1, 1, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        drive(1, 0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drive(1, 1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        repeat (5) drive(1, 0, '0, '0, 1'b0, 1'b0);

        // stream with toggling in_valid and a two-cycle stall while ops are in flight
        for (int i = 0; i < 10; i++) begin
            drive(!(i == 5 || i == 6), (i < 3) ? 1'b1 : 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // longer random run with occasional stalls
        for (int i = 0; i < 150; i++) begin
            drive(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // reset with operations in flight: outputs clear at once, nothing stale afterwards
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, $urandom | 32'h1, $urandom, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'(0));
        check("async_reset_sum", 64'(sum), 64'(0));
        check("async_reset_co", 64'(co), 64'(0));
        check("async_reset_ovf", 64'(ovf), 64'(0));
        dropped = exp_q.size();
        accepted = accepted - dropped;
        exp_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) drive(1, 0, $urandom, $urandom, 1'b0, 1'b0);
        drive(1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drive(1, 1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);

        // single-stage instance
        drive(1, 0, '0, '0, 1'b0, 1'b0);
        drive2(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drive2(0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive2(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid2 = 1'b0;

        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) begin
            drive(1, 0, '0, '0, 1'b0, 1'b0);
        end
        check("drain_main", 64'(exp_q.size()), 64'(0));
        check("drain_16", 64'(exp2_q.size()), 64'(0));
        check("count_main", 64'(seen), 64'(accepted));
        check("count_16", 64'(seen2), 64'(accepted2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder_carry.md
# pipelined_adder_carry

Parametrised, pipelined unsigned adder/subtractor with carry-in, carry-out and signed-overflow flag. It is the registered successor of the team's 8-bit combinational carry adder, for datapaths where a full-width carry chain cannot close timing. The operand is split into SEG-bit segments, with one segment's carry resolved per pipeline stage. Results are de-skewed so every SUM bit emerges in the same cycle, with a valid flag and a global stall (EN).

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of SEG.
- SEG, 8: segment width in bits. STAGES = WIDTH/SEG is the pipeline depth; SEG = WIDTH gives a single registered stage.
- CLK  input  1  sole clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  pipeline advance; when 0, every register holds its value.
- IN_VALID  input  1  A, B, CI and SUB carry a valid operation this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- CI  input  1  carry-in.
- SUB  input  1  0: compute A + B + CI. 1: compute A + ~B + CI; with CI = 1 this gives A − B.
- OUT_VALID  output  1  SUM, CO and OVF hold a new result this cycle.
- SUM  output  WIDTH  result, modulo 2^WIDTH.
- CO  output  1  carry out of bit WIDTH−1.
- OVF  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- Effective operand: B' = SUB ? ~B : B, formed combinationally at the input.
- Stage k (k = 0..STAGES−1):
  - adds segment k of A and B' plus the carry registered by stage k−1;
  - stage 0 uses CI as its incoming carry;
  - produces SEG sum bits plus a 1-bit carry.
- Skew registers delay the upper segments of A and B' so that segment k reaches stage k exactly k cycles after sampling.
- De-skew registers delay the lower result segments so that all segments of one operation reach the output together.
- Valid bits travel down a STAGES-deep shift register in lockstep with the data.
- Final stage:
  - CO = carry out of the last segment.
  - OVF = carry into bit WIDTH−1 XOR CO. The last stage computes its top bit separately to expose the carry into bit WIDTH−1.
- Output registers (SUM, CO, OVF) load only on an enabled edge where the final-stage valid bit is 1. Otherwise they hold the last valid result.
- OUT_VALID is the final-stage valid bit. It is high for exactly one enabled cycle per accepted operation, or held while EN = 0.
- Internal data registers advance on every enabled edge whether or not IN_VALID is set. Bubble data never reaches SUM.
- Width rules: all internal sums are SEG+1 bits. No other truncation.

## Timing
- Reset (RST_N = 0, asynchronous, no clock needed): OUT_VALID = 0, SUM = 0, CO = 0, OVF = 0, all valid bits 0. All in-flight operations are discarded.
- Reset release: the first enabled edge after RST_N rises can accept an operation.
- Latency: an operation sampled on enabled edge n is visible on the outputs after enabled edge n+STAGES−1. Counting the sampling edge, the result appears STAGES enabled edges later; SEG = WIDTH gives 1.
- Throughput: one operation per enabled cycle. There is no backpressure other than EN.
- EN = 0:
  - A, B, CI, SUB and IN_VALID are ignored.
  - All outputs, including OUT_VALID, hold.
  - Latency stretches by the number of stalled cycles; ordering is preserved.
- Simultaneous EN = 0 and reset: reset wins.
- IN_VALID = 0 on an enabled edge inserts a bubble. OUT_VALID is 0 in the matching output cycle and SUM/CO/OVF hold.
- Carry ripple across all segments (e.g. FFFF…F + 1) costs no extra cycles.

## Test plan
1. **Reset.** Drive RST_N = 0 mid-stream with four operations in flight, at WIDTH = 32, SEG = 8 → OUT_VALID, SUM, CO, OVF go to 0 immediately without a clock edge. No stale result appears after release.
2. **Full carry ripple.** A = FFFFFFFF, B = 00000000, CI = 1, SUB = 0 → after the 4th enabled edge: SUM = 00000000, CO = 1, OVF = 0, OUT_VALID high for 1 cycle.
3. **Signed overflow.** A = 7FFFFFFF, B = 00000001, CI = 0 → SUM = 80000000, CO = 0, OVF = 1.
4. **Subtract.** SUB = 1, CI = 1:
   - A = 5, B = 7 → SUM = FFFFFFFE, CO = 0, OVF = 0.
   - A = 7, B = 5 on the next cycle → SUM = 00000002, CO = 1, OVF = 0.
5. **Stall and bubbles.** Stream 8 random operations with IN_VALID toggling, and hold EN = 0 for 2 cycles mid-stream → results match a reference model in order, with no loss or duplication. OUT_VALID count equals accepted count, and latency grows by exactly 2 for operations in flight during the stall.
6. **Single-stage configuration.** WIDTH = 16, SEG = 16, A = FFFF, B = 0001, CI = 0 → SUM = 0000, CO = 1, OVF = 0, one cycle after sampling.
